uart_msg_rx: RTL and testbench
==============================

# uart_msg_rx

UART receive path feeding the SHA-256 core: deserialises 8N1 bytes from the board RXD pin and accumulates a text line. On each line feed it emits one fully padded 512-bit SHA-256 block: message bytes, 0x80, zeros, and the 64-bit big-endian bit length. It sits between RXD and `sha256.M`, and is the receive-side counterpart of the transmitter that returns the hex digest.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate; bit period BIT = CLK_FREQ/BAUD clocks (integer division, 868 at defaults).
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- rxd  in  1  UART line; idle high; asynchronous to clk.
- rx_data  out  8  last correctly framed byte.
- rx_strobe  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overflow  out  1  one-cycle pulse when a data byte arrives with 55 bytes already buffered.
- msg  out  [0:511]  padded block; bit 0 = MSB of byte 0; held stable between msg_valid pulses.
- msg_len  out  6  byte count of the block in msg (0..55).
- msg_valid  out  1  one-cycle pulse; msg and msg_len are valid from this cycle onward.

## Operation
- rxd passes through a 2-flop synchroniser (reset value 1). All logic below uses the synchronised value `rs`.
- Receiver FSM:
  - IDLE: on `rs`=0, go to START and load the bit counter with BIT/2-1.
  - START: when the counter reaches 0, sample. If `rs`=1 (glitch), return to IDLE silently. Otherwise go to DATA with bit index 0 and counter BIT-1.
  - DATA: on each counter expiry, shift `rs` in LSB-first and reload the counter with BIT-1. After bit 7, go to STOP.
  - STOP: on counter expiry, sample.
    - `rs`=1: latch the byte, pulse rx_strobe and pass the byte to the assembler.
    - `rs`=0: pulse frame_err and drop the byte.
    - Either way, return to IDLE. A frame error does not alter the buffer.
- Assembler: holds a 55-byte buffer and a 6-bit count `len`.
  - 0x0D: ignored. It is still reported on rx_data/rx_strobe.
  - 0x0A (terminator): in one cycle, build msg:
    - bytes 0..len-1 = buffer;
    - byte len = 0x80;
    - bytes len+1..55 = 0x00;
    - bits 448..511 = len*8 as a 64-bit big-endian value.
    - Then set msg_len = len, pulse msg_valid and clear len to 0.
    - An empty line yields the empty-string block.
  - Any other byte: if len<55, store it at index len and increment len. If len==55, drop it, pulse overflow and leave len at 55. Only the first 55 bytes of the line are kept.
- Bytes at buffer index ≥ len never reach msg (they are masked), so the buffer does not need clearing.
- Reset values: rx_data=0, rx_strobe=0, frame_err=0, overflow=0, msg=0, msg_len=0, msg_valid=0, len=0, FSM=IDLE, synchroniser=1.
- Reset asserted mid-frame or mid-line: the partial byte and line are discarded. Reception restarts at the next falling edge after release.

## Timing
- Sampling points: start bit at BIT/2 clocks after `rs` falls; data bit n at BIT/2 + (n+1)·BIT; stop bit at BIT/2 + 9·BIT.
- Input-to-`rs` latency: 2 clocks.
- rx_strobe, frame_err and overflow assert in the cycle after the stop-bit sample.
- msg_valid asserts 1 cycle after rx_strobe for the 0x0A byte, so 2 cycles after the stop sample. msg and msg_len change in that same cycle.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP. Receiving at full line rate produces no loss.
- Simultaneous events: no byte-level events can coincide, since at most one byte completes per frame. msg_valid for line N and buffer writes for line N+1 never overlap.
- Throughput: one block per line, with no back-pressure. A downstream consumer must capture msg before the next msg_valid pulse.

## Test plan
- Send "abc\n" at 115200 baud with defaults. Required response:
  - msg = 0x61626380 followed by zeros, with bits 448..511 = 0x18 and msg_len=3;
  - one msg_valid pulse;
  - sha256 of msg = ba7816bf…f20015ad.
- Send "\n" alone. Required: msg = 0x80, then zeros, with a length field of 0; msg_len=0; sha256 of msg = e3b0c442…7852b855.
- Send 57×'a' then "\r\n". Required:
  - overflow pulses exactly twice;
  - msg_len=55, bytes 0..54 = 0x61, byte 55 = 0x80, length field = 0x1B8;
  - the 0x0D byte does not appear in msg.
- Send a frame with the stop bit driven low, then "x\n". Required: one frame_err pulse; msg_len=1 and byte 0 = 0x78.
- Drive an rxd low glitch of BIT/4 clocks, then idle. Required: no rx_strobe and no frame_err; the FSM is back in IDLE.
- Assert reset in the middle of bit 4 of "q" in the line "pq\n", then release and send "z\n". Required:
  - all outputs read their reset values during reset;
  - the next msg has msg_len=1 and byte 0 = 0x7A.

Source files
------------

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: 8N1 UART receiver plus line assembler. Each line feed produces
// one fully padded 512-bit SHA-256 message block for the hash core.
`timescale 1ns/1ps
module uart_msg_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rxd,
  output logic [7:0]   rx_data,
  output logic         rx_strobe,
  output logic         frame_err,
  output logic         overflow,
  output logic [0:511] msg,
  output logic [5:0]   msg_len,
  output logic         msg_valid
);

  localparam int BIT     = CLK_FREQ / BAUD;
  localparam int CW      = (BIT > 2) ? $clog2(BIT) : 1;
  localparam int MAX_LEN = 55;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT - 1);
  localparam logic [5:0]    LEN_FULL  = 6'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic         rxd_meta_reg, rs_reg;
  state_t       state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]   idx_reg, idx_next;
  logic [7:0]   shift_reg, shift_next;
  logic         byte_done, stop_bad;

  logic [7:0]   rx_data_reg;
  logic         rx_strobe_reg, frame_err_reg, overflow_reg;
  logic [0:511] msg_reg;
  logic [5:0]   msg_len_reg;
  logic         msg_valid_reg;
  logic [5:0]   len_reg;
  logic [7:0]   buf_mem [0:MAX_LEN-1];
  logic [0:511] msg_build;

  logic is_ctrl, store_en, ovf_hit, terminate;

  // Two-flop synchroniser; idle-high reset value so no false start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_reg <= 1'b1;
      rs_reg       <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rs_reg       <= rxd_meta_reg;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Receiver next state: mid-bit sampling driven by a down-counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rs_reg) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          if (rs_reg) begin
            state_next = IDLE;          // glitch shorter than half a bit
          end else begin
            state_next = DATA;
            idx_next   = 3'd0;
            cnt_next   = FULL_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rs_reg, shift_reg[7:1]};
          cnt_next   = FULL_LOAD;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          if (rs_reg) byte_done = 1'b1;
          else        stop_bad  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer writes are decided at the stop sample so overflow lines up with rx_strobe.
  assign is_ctrl   = (shift_reg == 8'h0A) || (shift_reg == 8'h0D);
  assign store_en  = byte_done && !is_ctrl && (len_reg < LEN_FULL);
  assign ovf_hit   = byte_done && !is_ctrl && (len_reg >= LEN_FULL);
  assign terminate = rx_strobe_reg && (rx_data_reg == 8'h0A);

  // Line buffer storage; stale bytes past len are masked when the block is built.
  always_ff @(posedge clk) begin
    if (store_en) buf_mem[len_reg] <= shift_reg;
  end

  // Padded block: data bytes, 0x80 marker, zero fill, 64-bit big-endian bit count.
  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_byte
      if (gi < MAX_LEN) begin : g_buf
        assign msg_build[gi*8 +: 8] = (6'(gi) < len_reg)  ? buf_mem[gi] :
                                      (6'(gi) == len_reg) ? 8'h80 : 8'h00;
      end else begin : g_pad
        assign msg_build[gi*8 +: 8] = (6'(gi) == len_reg) ? 8'h80 : 8'h00;
      end
    end
  endgenerate
  assign msg_build[448 +: 64] = {55'd0, len_reg, 3'b000};

  // Byte-level event pulses, line length and the emitted block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_reg   <= '0;
      rx_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      msg_reg       <= '0;
      msg_len_reg   <= '0;
      msg_valid_reg <= 1'b0;
      len_reg       <= '0;
    end else begin
      rx_strobe_reg <= byte_done;
      frame_err_reg <= stop_bad;
      overflow_reg  <= ovf_hit;
      msg_valid_reg <= terminate;
      if (byte_done) rx_data_reg <= shift_reg;
      if (terminate) begin
        msg_reg     <= msg_build;
        msg_len_reg <= len_reg;
        len_reg     <= '0;
      end else if (store_en) begin
        len_reg <= len_reg + 6'd1;
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_strobe = rx_strobe_reg;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;
  assign msg       = msg_reg;
  assign msg_len   = msg_len_reg;
  assign msg_valid = msg_valid_reg;

endmodule

// File: tb/tb_uart_msg_rx.sv
// Self-checking bench for uart_msg_rx: table of lines with hand-derived blocks,
// corner-case sequences (frame error, glitch, reset mid-frame) and random lines
// checked against a queue-based padding model.
`timescale 1ns/1ps
module tb_uart_msg_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BIT      = CLK_FREQ / BAUD;   // 16 clocks per bit

  typedef byte unsigned bq_t[$];

  typedef struct {
    byte unsigned data [0:63];
    int           n;
    int           exp_len;
    int           exp_ovf;
    logic [0:511] exp_msg;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         rxd;
  logic [7:0]   rx_data;
  logic         rx_strobe, frame_err, overflow;
  logic [0:511] msg;
  logic [5:0]   msg_len;
  logic         msg_valid;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0, n_ferr = 0, n_ovf = 0;
  logic [0:511] cap_msg[$];
  int           cap_len[$];
  byte unsigned exp_rx[$];
  vec_t         vecs [0:3];

  always #5 clk = ~clk;

  uart_msg_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .frame_err(frame_err),
    .overflow(overflow), .msg(msg), .msg_len(msg_len), .msg_valid(msg_valid)
  );

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Count pulses, check every received byte, capture emitted blocks.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_strobe) begin
        n_strobe++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_data: unexpected byte %02h", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (frame_err) n_ferr++;
      if (overflow)  n_ovf++;
      if (msg_valid) begin
        cap_msg.push_back(msg);
        cap_len.push_back(int'(msg_len));
      end
    end
  end

  // Reference: drop CR, stop at LF, keep first 55 bytes, then pad.
  function automatic logic [0:511] model_block(input bq_t q, output int n_len, output int n_ovf);
    byte unsigned kept[$];
    logic [0:511] blk;
    n_ovf = 0;
    foreach (q[i]) begin
      if (q[i] == 8'h0A) break;
      if (q[i] != 8'h0D) begin
        if (kept.size() < 55) kept.push_back(q[i]);
        else n_ovf++;
      end
    end
    n_len = kept.size();
    blk = '0;
    foreach (kept[i]) blk[i*8 +: 8] = kept[i];
    blk[n_len*8 +: 8] = 8'h80;
    blk[448 +: 64] = 64'(n_len) * 64'd8;
    return blk;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic vec_t make_vec(input string s, input int el, input int eo, input logic [0:511] em);
    vec_t v;
    v.data = '{default: 8'h00};
    v.n = s.len();
    for (int i = 0; i < s.len(); i++) v.data[i] = s[i];
    v.exp_len = el;
    v.exp_ovf = eo;
    v.exp_msg = em;
    return v;
  endfunction

  task automatic send_byte(input byte unsigned b, input bit stop_hi);
    if (stop_hi) exp_rx.push_back(b);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_hi) begin
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      // Low long enough to be sampled, released early so no new frame starts.
      rxd = 1'b0;
      repeat (BIT/2 + 2) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT - BIT/2 - 2) @(negedge clk);
    end
  endtask

  task automatic run_line(input bq_t q, input int exp_len, input int exp_ovf,
                          input logic [0:511] exp_msg, input string name);
    int s0, f0, o0, waited;
    logic [0:511] m;
    int l;
    s0 = n_strobe; f0 = n_ferr; o0 = n_ovf; waited = 0;
    foreach (q[i]) begin
      send_byte(q[i], 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    while (cap_msg.size() == 0 && waited < 4*BIT) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    chk({name, " msg_valid_count"}, cap_msg.size(), 1);
    l = -1;
    if (cap_msg.size() > 0) begin
      m = cap_msg.pop_front();
      l = cap_len.pop_front();
      chk({name, " msg"}, m, exp_msg);
      chk({name, " msg_len"}, l, exp_len);
    end
    cap_msg.delete();
    cap_len.delete();
    chk({name, " overflow_count"}, n_ovf - o0, exp_ovf);
    chk({name, " frame_err_count"}, n_ferr - f0, 0);
    chk({name, " rx_strobe_count"}, n_strobe - s0, q.size());
    $display("line %s: %0d bytes sent, msg_len=%0d, overflow pulses=%0d", name, q.size(), l, n_ovf - o0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rx_data"},   rx_data,   0);
    chk({tag, " rx_strobe"}, rx_strobe, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " overflow"},  overflow,  0);
    chk({tag, " msg"},       msg,       0);
    chk({tag, " msg_len"},   msg_len,   0);
    chk({tag, " msg_valid"}, msg_valid, 0);
    $display("reset check %s: rx_data=%02h msg_len=%0d", tag, rx_data, msg_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    string s;
    int el, eo;
    logic [0:511] em;
    byte unsigned q_byte;
    int s0, f0;

    s = "";
    repeat (57) s = {s, "a"};
    s = {s, "\015\n"};
    vecs[0] = make_vec("abc\n", 3, 0, {32'h61626380, 416'h0, 64'h18});
    vecs[1] = make_vec("\n", 0, 0, {8'h80, 440'h0, 64'h0});
    vecs[2] = make_vec("hello\015\n", 5, 0, {40'h68656c6c6f, 8'h80, 400'h0, 64'h28});
    vecs[3] = make_vec(s, 55, 2, {{55{8'h61}}, 8'h80, 64'h1B8});

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("power_on");
    reset = 1'b0;
    repeat (2*BIT) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      q.delete();
      for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].data[k]);
      run_line(q, vecs[i].exp_len, vecs[i].exp_ovf, vecs[i].exp_msg, $sformatf("vec%0d", i));
    end

    // Stop bit low: one frame error, byte dropped, buffer untouched.
    s0 = n_strobe; f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    repeat (3*BIT) @(negedge clk);
    chk("ferr frame_err_count", n_ferr - f0, 1);
    chk("ferr rx_strobe_count", n_strobe - s0, 0);
    chk("ferr no_msg", cap_msg.size(), 0);
    $display("frame error byte: frame_err pulses=%0d", n_ferr - f0);
    run_line(str2q("x\n"), 1, 0, {8'h78, 8'h80, 432'h0, 64'h8}, "after_ferr");

    // Quarter-bit low glitch must be rejected silently.
    s0 = n_strobe; f0 = n_ferr;
    rxd = 1'b0;
    repeat (BIT/4) @(negedge clk);
    rxd = 1'b1;
    repeat (3*BIT) @(negedge clk);
    chk("glitch rx_strobe_count", n_strobe - s0, 0);
    chk("glitch frame_err_count", n_ferr - f0, 0);
    $display("glitch: strobes=%0d frame_errs=%0d", n_strobe - s0, n_ferr - f0);
    run_line(str2q("ok\n"), 2, 0, {16'h6f6b, 8'h80, 424'h0, 64'h10}, "after_glitch");

    // Reset in the middle of bit 4 of 'q' in "pq\n".
    send_byte(8'h70, 1'b1);
    q_byte = 8'h71;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = q_byte[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = q_byte[4];
    repeat (BIT/2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_frame");
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rx.delete();
    repeat (2*BIT) @(negedge clk);
    run_line(str2q("z\n"), 1, 0, {8'h7a, 8'h80, 432'h0, 64'h8}, "after_reset");

    // Random lines against the padding model.
    for (int r = 0; r < 5; r++) begin
      q.delete();
      repeat ($urandom_range(0, 62)) begin
        if ($urandom_range(0, 9) == 0) q.push_back(8'h0D);
        else q.push_back(8'($urandom_range(32, 126)));
      end
      q.push_back(8'h0A);
      em = model_block(q, el, eo);
      run_line(q, el, eo, em, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
